// File: rtl/mul_share_ctrl_if.sv
// Handshake bundle between the two clients, the shared multiplier core and mul_share_ctrl.
// The controller uses the slave view; the client/core side uses the master view.
interface mul_share_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic [1:0]         rsp_valid;
   logic [1:0]         rsp_ready;
   logic [2*WIDTH-1:0] rsp_o;
   logic               rsp_err;
   logic               mul_in_valid;
   logic               mul_in_ready;
   logic [WIDTH-1:0]   mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic               mul_out_valid;
   logic [2*WIDTH-1:0] mul_o;
   logic               busy;
   logic               timeout_sticky;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_in_ready, mul_out_valid, mul_o,
      output req_ready, rsp_valid, rsp_o, rsp_err, mul_in_valid, mul_a, mul_b,
             busy, timeout_sticky
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_in_ready, mul_out_valid, mul_o,
      input  req_ready, rsp_valid, rsp_o, rsp_err, mul_in_valid, mul_a, mul_b,
             busy, timeout_sticky
   );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one multiplier core between two clients, with a
// start handshake toward the core, a per-client response channel and a watchdog.
module mul_share_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 2*WIDTH+4
) (
   input logic            clk,
   input logic            rst,
   mul_share_ctrl_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t             r_state;
   logic               r_prio;
   logic               r_gnt_id;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_res;
   logic               r_err;
   logic [CW-1:0]      r_wd_cnt;
   logic               r_mul_in_valid;
   logic [1:0]         r_rsp_valid;
   logic               r_busy;
   logic               r_timeout_sticky;

   logic [WIDTH-1:0]   w_req_a [2];
   logic [WIDTH-1:0]   w_req_b [2];
   logic [1:0]         w_req_ready;
   logic               w_gnt;
   logic               w_offer;
   logic               w_accept;

   // Ties go to r_prio; a lone requester wins regardless of priority.
   assign w_gnt    = (bus.req_valid == 2'b11) ? r_prio : bus.req_valid[1];
   assign w_offer  = (r_state == S_IDLE) && !rst && (|bus.req_valid);
   assign w_accept = |w_req_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign w_req_a[gi]     = bus.req_a[gi*WIDTH +: WIDTH];
         assign w_req_b[gi]     = bus.req_b[gi*WIDTH +: WIDTH];
         assign w_req_ready[gi] = w_offer && (w_gnt == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_prio           <= 1'b0;
         r_gnt_id         <= 1'b0;
         r_a              <= '0;
         r_b              <= '0;
         r_res            <= '0;
         r_err            <= 1'b0;
         r_wd_cnt         <= '0;
         r_mul_in_valid   <= 1'b0;
         r_rsp_valid      <= 2'b00;
         r_busy           <= 1'b0;
         r_timeout_sticky <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a            <= w_req_a[w_gnt];
                  r_b            <= w_req_b[w_gnt];
                  r_gnt_id       <= w_gnt;
                  r_mul_in_valid <= 1'b1;
                  r_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.mul_in_ready) begin
                  r_mul_in_valid <= 1'b0;
                  r_wd_cnt       <= '0;
                  r_state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
               // A finish pulse landing on the last watchdog cycle still counts as success.
               if (bus.mul_out_valid) begin
                  r_res       <= bus.mul_o;
                  r_err       <= 1'b0;
                  r_rsp_valid <= r_gnt_id ? 2'b10 : 2'b01;
                  r_state     <= S_RESP;
               end else if (r_wd_cnt == CW'(TIMEOUT-1)) begin
                  r_res            <= '0;
                  r_err            <= 1'b1;
                  r_timeout_sticky <= 1'b1;
                  r_rsp_valid      <= r_gnt_id ? 2'b10 : 2'b01;
                  r_state          <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready[r_gnt_id]) begin
                  r_prio      <= ~r_gnt_id;
                  r_rsp_valid <= 2'b00;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready      = w_req_ready;
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_o          = r_res;
   assign bus.rsp_err        = r_err;
   assign bus.mul_in_valid   = r_mul_in_valid;
   assign bus.mul_a          = r_a;
   assign bus.mul_b          = r_b;
   assign bus.busy           = r_busy;
   assign bus.timeout_sticky = r_timeout_sticky;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: a latency-programmable core model plus job-level
// round-robin/product expectations derived from the block's rules.
module tb_mul_share_ctrl;
   localparam int W  = 8;
   localparam int TO = 2*W+4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_share_ctrl_if #(.WIDTH(W)) bus ();
   mul_share_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   // core model state
   bit             core_busy = 0;
   bit             core_dead = 0;
   int             core_left = 0;
   int             core_lat  = 1;
   int             stall     = 0;
   logic [2*W-1:0] core_prod = '0;
   // job-level arbitration model
   logic           m_prio    = 1'b0;

   // Advance one clock; afterwards the bench sits 1 time unit past the edge.
   task automatic cycle();
      logic hs;
      logic [2*W-1:0] p;
      hs = bus.mul_in_valid && bus.mul_in_ready;
      p  = {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};
      @(posedge clk);
      #1;
      cyc++;
      bus.mul_out_valid = 1'b0;
      bus.mul_o         = '1;
      if (stall > 0) stall--;
      if (hs) begin
         core_busy = 1; core_left = core_lat; core_prod = p;
      end
      if (core_busy) begin
         core_left--;
         if (core_left <= 0) begin
            core_busy = 0;
            if (!core_dead) begin
               bus.mul_out_valid = 1'b1;
               bus.mul_o         = core_prod;
            end
         end
      end
      bus.mul_in_ready = !core_busy && (stall == 0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
      bus.mul_out_valid = 1'b0; bus.mul_in_ready = 1'b1;
      core_busy = 0; core_dead = 0; stall = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_prio = 1'b0;
   endtask

   // Drives one job end to end and reports what it observed; callers judge the results.
   task automatic do_job(input logic [1:0] v, input logic [W-1:0] a0, b0, a1, b1,
                         input int rdel, input bit hold,
                         output logic [1:0] rr, output logic [1:0] rbits,
                         output logic [2*W-1:0] prod, output logic err, output int lat,
                         output logic iv, output logic [W-1:0] ia, output logic [W-1:0] ib,
                         output bit to);
      int t_acc;
      to = 0; rr = 2'b00; rbits = 2'b00; prod = '0; err = 1'b0; lat = 0;
      iv = 1'b0; ia = '0; ib = '0;
      bus.req_valid = v; bus.req_a = {a1, a0}; bus.req_b = {b1, b0}; bus.rsp_ready = 2'b00;
      #1;
      for (int i = 0; i < 100 && bus.req_ready == 2'b00; i++) begin cycle(); #1; end
      if (bus.req_ready == 2'b00) begin to = 1; bus.req_valid = 2'b00; return; end
      rr = bus.req_ready; t_acc = cyc;
      cycle();
      if (!hold) bus.req_valid = 2'b00;
      #1;
      iv = bus.mul_in_valid; ia = bus.mul_a; ib = bus.mul_b;
      for (int i = 0; i < 100 && bus.rsp_valid == 2'b00; i++) begin cycle(); #1; end
      if (bus.rsp_valid == 2'b00) begin to = 1; return; end
      rbits = bus.rsp_valid; prod = bus.rsp_o; err = bus.rsp_err; lat = cyc - t_acc;
      for (int i = 0; i < rdel; i++) begin cycle(); #1; end
      bus.rsp_ready = rbits;
      cycle();
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_reset();
      bus.req_valid = 2'b11; bus.req_a = '0; bus.req_b = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); else n_pass++;
      n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); else n_pass++;
      n_checks++; if (bus.mul_in_valid !== 1'b0) $display("FAIL reset_mul_in_valid: got %b want 0", bus.mul_in_valid); else n_pass++;
      n_checks++; if ({bus.mul_a, bus.mul_b} !== '0) $display("FAIL reset_mul_ab: got %h want 0", {bus.mul_a, bus.mul_b}); else n_pass++;
      n_checks++; if ({bus.rsp_o, bus.rsp_err} !== '0) $display("FAIL reset_rsp_o_err: got %h want 0", {bus.rsp_o, bus.rsp_err}); else n_pass++;
      n_checks++; if ({bus.busy, bus.timeout_sticky} !== 2'b00) $display("FAIL reset_busy_sticky: got %b want 00", {bus.busy, bus.timeout_sticky}); else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL reset_first_grant: got %b want 01", bus.req_ready); else n_pass++;
      bus.req_valid = 2'b00;
      cycle();
   endtask

   task automatic test_single();
      logic [1:0] rr, rb; logic [2*W-1:0] p; logic e, iv; logic [W-1:0] ia, ib; int lat; bit to;
      core_lat = 5;
      do_job(2'b01, 8'd13, 8'd11, 8'd0, 8'd0, 1, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
      $display("single: rr=%b rsp=%b prod=%0d err=%0d lat=%0d", rr, rb, p, e, lat);
      n_checks++; if (to) $display("FAIL single_timeout: no handshake within bound"); else n_pass++;
      n_checks++; if (rr !== 2'b01) $display("FAIL single_req_ready: got %b want 01", rr); else n_pass++;
      n_checks++; if ({iv, ia, ib} !== {1'b1, 8'd13, 8'd11}) $display("FAIL single_issue: got v=%b a=%0d b=%0d want 1/13/11", iv, ia, ib); else n_pass++;
      n_checks++; if ({rb, e} !== {2'b01, 1'b0}) $display("FAIL single_rsp_bits: got %b err=%b want 01 err=0", rb, e); else n_pass++;
      n_checks++; if (p !== 16'd143) $display("FAIL single_product: got %0d want 143", p); else n_pass++;
      n_checks++; if (lat !== 7) $display("FAIL single_latency: got %0d want 7", lat); else n_pass++;
      m_prio = 1'b1;
   endtask

   task automatic test_fairness();
      logic [1:0] rr, rb; logic [2*W-1:0] p; logic e, iv; logic [W-1:0] ia, ib; int lat; bit to;
      logic eg; logic [2*W-1:0] ep;
      reset_dut();
      core_lat = 2;
      for (int j = 0; j < 4; j++) begin
         eg = m_prio;
         ep = eg ? 16'd30 : 16'd12;
         do_job(2'b11, 8'd3, 8'd4, 8'd5, 8'd6, 0, 1'b1, rr, rb, p, e, lat, iv, ia, ib, to);
         $display("fair %0d: rr=%b rsp=%b prod=%0d", j, rr, rb, p);
         n_checks++; if (to || rr !== (eg ? 2'b10 : 2'b01) || rb !== rr) $display("FAIL fair_grant_%0d: got rr=%b rsp=%b want gnt %0d", j, rr, rb, eg); else n_pass++;
         n_checks++; if (p !== ep) $display("FAIL fair_product_%0d: got %0d want %0d", j, p, ep); else n_pass++;
         m_prio = ~eg;
      end
      bus.req_valid = 2'b00;
      cycle();
   endtask

   task automatic test_stall();
      int n; bit bad;
      core_lat = 3;
      bus.req_valid = 2'b01; bus.req_a = {8'd0, 8'd200}; bus.req_b = {8'd0, 8'd250};
      #1;
      for (int i = 0; i < 100 && bus.req_ready == 2'b00; i++) begin cycle(); #1; end
      n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL stall_grant: got %b want 01", bus.req_ready); else n_pass++;
      cycle();
      bus.req_valid = 2'b00; stall = 4; bus.mul_in_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         bus.req_a = W*2'($urandom); bus.req_b = W*2'($urandom);
         #1;
         if (bus.mul_in_valid !== 1'b1 || bus.mul_a !== 8'd200 || bus.mul_b !== 8'd250 || bus.rsp_valid !== 2'b00) bad = 1;
         if (i == 1) begin bus.mul_out_valid = 1'b1; bus.mul_o = '0; end
         cycle();
      end
      n_checks++; if (bad) $display("FAIL stall_hold: issue not held stable, v=%b a=%0d b=%0d", bus.mul_in_valid, bus.mul_a, bus.mul_b); else n_pass++;
      #1;
      n_checks++; if ({bus.mul_in_ready, bus.mul_in_valid} !== 2'b11) $display("FAIL stall_handshake_cycle: got rdy/vld %b want 11", {bus.mul_in_ready, bus.mul_in_valid}); else n_pass++;
      cycle(); #1;
      n_checks++; if (bus.mul_in_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL stall_wait_entry: got vld=%b busy=%b want 0/1", bus.mul_in_valid, bus.busy); else n_pass++;
      n = 0;
      for (int i = 0; i < 100 && bus.rsp_valid == 2'b00; i++) begin cycle(); #1; n++; end
      n_checks++; if (bus.rsp_valid !== 2'b01 || n != 3) $display("FAIL stall_rsp: got %b after %0d want 01 after 3", bus.rsp_valid, n); else n_pass++;
      n_checks++; if (bus.rsp_o !== 16'd50000) $display("FAIL stall_product: got %0d want 50000", bus.rsp_o); else n_pass++;
      bus.rsp_ready = 2'b01; cycle(); bus.rsp_ready = 2'b00;
      m_prio = 1'b1;
   endtask

   task automatic test_spurious_idle();
      logic [1:0] rr, rb; logic [2*W-1:0] p; logic e, iv; logic [W-1:0] ia, ib; int lat; bit to;
      bus.mul_out_valid = 1'b1; bus.mul_o = 16'h1234;
      cycle(); #1;
      n_checks++; if ({bus.busy, bus.rsp_valid} !== 3'b000) $display("FAIL spurious_idle: got busy=%b rsp=%b want 0/00", bus.busy, bus.rsp_valid); else n_pass++;
      core_lat = 1;
      do_job(2'b10, 8'd0, 8'd0, 8'd0, 8'd77, 0, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
      n_checks++; if (to || rb !== 2'b10 || p !== 16'd0 || e !== 1'b0 || lat !== 3) $display("FAIL zero_operand_job: got rsp=%b prod=%0d err=%b lat=%0d want 10/0/0/3", rb, p, e, lat); else n_pass++;
      m_prio = 1'b0;
   endtask

   task automatic test_backpressure();
      bit bad;
      core_lat = 2;
      bus.req_valid = 2'b10; bus.req_a = {8'd9, 8'd2}; bus.req_b = {8'd7, 8'd3};
      #1;
      for (int i = 0; i < 100 && bus.req_ready == 2'b00; i++) begin cycle(); #1; end
      n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL bp_grant1: got %b want 10", bus.req_ready); else n_pass++;
      cycle();
      bus.req_valid = 2'b01;
      #1;
      for (int i = 0; i < 100 && bus.rsp_valid == 2'b00; i++) begin cycle(); #1; end
      n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_o !== 16'd63) $display("FAIL bp_rsp1: got %b/%0d want 10/63", bus.rsp_valid, bus.rsp_o); else n_pass++;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         bus.rsp_ready = 2'b01;
         #1;
         if (bus.rsp_o !== 16'd63 || bus.rsp_valid !== 2'b10 || bus.req_ready !== 2'b00) bad = 1;
         cycle();
      end
      n_checks++; if (bad) $display("FAIL bp_hold: got rsp=%b o=%0d req_ready=%b want 10/63/00", bus.rsp_valid, bus.rsp_o, bus.req_ready); else n_pass++;
      bus.rsp_ready = 2'b10;
      cycle();
      bus.rsp_ready = 2'b00;
      #1;
      n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL bp_next_grant: got %b want 01", bus.req_ready); else n_pass++;
      cycle();
      bus.req_valid = 2'b00;
      #1;
      for (int i = 0; i < 100 && bus.rsp_valid == 2'b00; i++) begin cycle(); #1; end
      n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_o !== 16'd6) $display("FAIL bp_rsp0: got %b/%0d want 01/6", bus.rsp_valid, bus.rsp_o); else n_pass++;
      bus.rsp_ready = 2'b01; cycle(); bus.rsp_ready = 2'b00;
      m_prio = 1'b1;
   endtask

   task automatic test_watchdog();
      logic [1:0] rr, rb; logic [2*W-1:0] p; logic e, iv; logic [W-1:0] ia, ib; int lat; bit to;
      core_lat = 3; core_dead = 1;
      do_job(2'b01, 8'd5, 8'd5, 8'd0, 8'd0, 2, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
      $display("watchdog: rsp=%b prod=%0d err=%0d lat=%0d sticky=%b", rb, p, e, lat, bus.timeout_sticky);
      n_checks++; if (to || rb !== 2'b01 || e !== 1'b1 || p !== '0) $display("FAIL wd_rsp: got rsp=%b err=%b prod=%0d want 01/1/0", rb, e, p); else n_pass++;
      n_checks++; if (lat !== 2 + TO) $display("FAIL wd_latency: got %0d want %0d", lat, 2 + TO); else n_pass++;
      n_checks++; if (bus.timeout_sticky !== 1'b1) $display("FAIL wd_sticky_set: got %b want 1", bus.timeout_sticky); else n_pass++;
      core_dead = 0;
      do_job(2'b10, 8'd0, 8'd0, 8'd7, 8'd8, 0, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
      n_checks++; if (to || rb !== 2'b10 || e !== 1'b0 || p !== 16'd56) $display("FAIL wd_good_after: got rsp=%b err=%b prod=%0d want 10/0/56", rb, e, p); else n_pass++;
      n_checks++; if (bus.timeout_sticky !== 1'b1) $display("FAIL wd_sticky_hold: got %b want 1", bus.timeout_sticky); else n_pass++;
      m_prio = 1'b0;
   endtask

   task automatic test_rst_mid();
      logic [1:0] rr, rb; logic [2*W-1:0] p; logic e, iv; logic [W-1:0] ia, ib; int lat; bit to; bit bad;
      core_lat = 6;
      bus.req_valid = 2'b10; bus.req_a = {8'd21, 8'd0}; bus.req_b = {8'd3, 8'd0};
      #1;
      for (int i = 0; i < 100 && bus.req_ready == 2'b00; i++) begin cycle(); #1; end
      cycle();
      bus.req_valid = 2'b00;
      cycle(); cycle();
      #2;
      n_checks++; if (bus.busy !== 1'b1 || bus.mul_in_valid !== 1'b0) $display("FAIL rst_mid_in_wait: got busy=%b vld=%b want 1/0", bus.busy, bus.mul_in_valid); else n_pass++;
      bus.req_valid = 2'b01;
      rst = 1'b1;
      #1;
      n_checks++; if ({bus.busy, bus.rsp_valid, bus.req_ready, bus.mul_in_valid, bus.timeout_sticky} !== 7'd0 || {bus.mul_a, bus.mul_b, bus.rsp_o, bus.rsp_err} !== '0) $display("FAIL rst_mid_outputs: got busy=%b rsp=%b rdy=%b vld=%b sticky=%b", bus.busy, bus.rsp_valid, bus.req_ready, bus.mul_in_valid, bus.timeout_sticky); else n_pass++;
      cycle();
      rst = 1'b0; bus.req_valid = 2'b00;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(); #1;
         if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) bad = 1;
      end
      n_checks++; if (bad) $display("FAIL rst_mid_no_rsp: got rsp=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); else n_pass++;
      m_prio = 1'b0;
      core_lat = 2;
      do_job(2'b11, 8'd15, 8'd15, 8'd2, 8'd2, 0, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
      n_checks++; if (to || rr !== 2'b01 || rb !== 2'b01 || p !== 16'd225 || e !== 1'b0) $display("FAIL rst_mid_next_job: got rr=%b rsp=%b prod=%0d err=%b want 01/01/225/0", rr, rb, p, e); else n_pass++;
      m_prio = 1'b1;
   endtask

   task automatic test_random();
      logic [1:0] rr, rb, v, eoh; logic [2*W-1:0] p, ep; logic e, iv, eg, ee; logic [W-1:0] ia, ib, a0, b0, a1, b1;
      int lat, el, rdel; bit to;
      for (int j = 0; j < 30; j++) begin
         v  = 2'($urandom_range(1, 3));
         a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
         core_lat  = $urandom_range(1, 8);
         core_dead = ($urandom_range(0, 7) == 0);
         rdel      = $urandom_range(0, 3);
         eg  = (v == 2'b11) ? m_prio : v[1];
         eoh = eg ? 2'b10 : 2'b01;
         ee  = core_dead;
         ep  = core_dead ? '0 : (eg ? {{W{1'b0}}, a1} * {{W{1'b0}}, b1} : {{W{1'b0}}, a0} * {{W{1'b0}}, b0});
         el  = core_dead ? 2 + TO : 2 + core_lat;
         do_job(v, a0, b0, a1, b1, rdel, 1'b0, rr, rb, p, e, lat, iv, ia, ib, to);
         $display("job %0d: v=%b rr=%b rsp=%b prod=%0d err=%0d lat=%0d", j, v, rr, rb, p, e, lat);
         n_checks++; if (to || rr !== eoh || rb !== eoh) $display("FAIL rand_grant_%0d: got rr=%b rsp=%b want %b", j, rr, rb, eoh); else n_pass++;
         n_checks++; if (p !== ep || e !== ee) $display("FAIL rand_result_%0d: got %0d err=%b want %0d err=%b", j, p, e, ep, ee); else n_pass++;
         n_checks++; if (lat !== el) $display("FAIL rand_latency_%0d: got %0d want %0d", j, lat, el); else n_pass++;
         m_prio = ~eg;
      end
      core_dead = 0;
   endtask

   initial begin
      bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 2'b00;
      bus.mul_in_ready = 1'b1; bus.mul_out_valid = 1'b0; bus.mul_o = '0;
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_spurious_idle();
      test_backpressure();
      test_watchdog();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time bound, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "time bound exceeded");
   end
endmodule
